mux_pipe_n: RTL
===============

MUX_PIPE_N -- requirements
Module: mux_pipe_n

Interface
REQ-001: Parameter WIDTH, default 32, data width in bits of each input and of the output.
REQ-002: Parameter NUM_IN, default 4, number of selectable inputs, legal range 2..16.
REQ-003: Derived constant SEL_W = clog2(NUM_IN), sel width; it SHALL NOT be overridable.
REQ-004: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005: rst  input  1  reset, synchronous, active-high.
REQ-006: in_data  input  NUM_IN*WIDTH  flattened inputs; input k SHALL occupy bits [k*WIDTH +: WIDTH].
REQ-007: sel  input  SEL_W  binary index of the input to capture.
REQ-008: in_valid  input  1  the producer offers in_data/sel this cycle.
REQ-009: in_ready  output  1  the block can accept this cycle.
REQ-010: flush  input  1  discard all buffered entries.
REQ-011: out_data  output  WIDTH  selected word at the buffer head.
REQ-012: out_sel  output  SEL_W  sel value captured with out_data.
REQ-013: out_valid  output  1  the buffer head is valid.
REQ-014: out_ready  input  1  the consumer takes the head this cycle.
REQ-015: sel_err  output  1  sticky flag: an out-of-range sel was accepted.

Function
REQ-016: The block SHALL hold a 2-entry in-order buffer with occupancy count 0..2.
REQ-017: Push SHALL occur when in_valid && in_ready; the stored word SHALL be input sel, plus sel itself.
REQ-018: in_ready SHALL be (count < 2) && !flush && !rst, combinationally.
REQ-019: Pop SHALL occur when out_valid && out_ready.
REQ-020: out_valid SHALL be (count != 0); out_data/out_sel SHALL be driven from registers, never combinationally from in_data.
REQ-021: Latency SHALL be 1 cycle: a push at edge t into an empty buffer SHALL be visible on out_* after edge t.
REQ-022: While out_valid && !out_ready, out_data and out_sel SHALL hold stable.
REQ-023: Simultaneous push and pop at count 1 SHALL leave count 1, with the new entry at the head after the edge.
REQ-024: At count 2, no push SHALL occur, since in_ready = 0; a pop SHALL reduce count to 1.
REQ-025: At count 0, a pop is impossible; out_data SHALL retain its last value.
REQ-026: flush SHALL set count to 0 at the next edge, overriding any same-cycle push or pop; out_data SHALL keep its last value.
REQ-027: If an accepted sel >= NUM_IN, the stored word SHALL be all-zero and sel_err SHALL set; sel_err SHALL clear only on rst.
REQ-028: Ordering SHALL be strict FIFO; no entry SHALL be duplicated or dropped except by flush or rst.

Reset
REQ-029: While rst is high at a clock edge: count, out_data, out_sel and sel_err SHALL clear to 0.
REQ-030: While rst is high, in_ready and out_valid SHALL read 0.
REQ-031: rst asserted mid-transfer SHALL discard all entries, with no partial word emitted afterwards.

Structure
REQ-032: The shared package/header SHALL hold the clog2 function and the default data width constant (32).
REQ-033: Storage SHALL be one sub-module, mux_pipe_fifo2 (2-entry WIDTH+SEL_W FIFO with flush).
REQ-034: Input selection SHALL be combinational logic in mux_pipe_n ahead of the FIFO.
REQ-035: Target size is 120-400 RTL lines.

Verification
REQ-036: Basic selection: NUM_IN=4, in_data words 0xA0,0xB1,0xC2,0xD3, sel=2, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, out_data=0xC2, out_sel=2.
REQ-037: Backpressure: out_ready=0, push sel=0 then sel=3 -> count 2, in_ready=0, out_data holds 0xA0; raise out_ready -> 0xA0 then 0xD3 on consecutive cycles.
REQ-038: Simultaneous push and pop: at count 1 with head 0xB1, push sel=3 with out_ready=1 -> after the edge count=1, out_data=0xD3.
REQ-039: Flush priority: count 2, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, no push recorded.
REQ-040: Out-of-range sel: NUM_IN=3, sel=3 accepted -> out_data=0, sel_err=1, stays 1 until rst.
REQ-041: Reset mid-operation: count 2, rst=1 for one cycle -> out_valid=0, out_data=0, sel_err=0; the next push delivers only the new word.

Source files
------------

// File: rtl/mux_pipe_n_pkg.sv
// Shared definitions for the mux_pipe_n block: default data width, the
// occupancy states of the 2-entry buffer, and a constant-foldable clog2.
package mux_pipe_n_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    // Returns the number of bits needed to index 'value' items (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_pipe_fifo2.sv
// Two-entry in-order buffer with flush. The head entry lives in its own
// register so the consumer always sees registered data.
module mux_pipe_fifo2
    import mux_pipe_n_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output fifo_state_e   state
);

    fifo_state_e   state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FIFO_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // push is never raised while full or flushing; pop never while empty.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FIFO_EMPTY;
        end else begin
            case (state_q)
                FIFO_EMPTY: if (push) state_d = FIFO_ONE;
                FIFO_ONE: begin
                    if (push && !pop)      state_d = FIFO_FULL;
                    else if (!push && pop) state_d = FIFO_EMPTY;
                end
                FIFO_FULL:  if (pop) state_d = FIFO_ONE;
                default:    state_d = FIFO_EMPTY;
            endcase
        end
    end

    // Emptying the buffer leaves the head register untouched so the last word lingers.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (!flush) begin
            case (state_q)
                FIFO_EMPTY: if (push) head_d = push_data;
                FIFO_ONE: begin
                    if (push && pop) head_d = push_data;
                    else if (push)   tail_d = push_data;
                end
                FIFO_FULL:  if (pop) head_d = tail_q;
                default: begin
                    head_d = head_q;
                    tail_d = tail_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_data = head_q;
    assign state     = state_q;

endmodule

// File: rtl/mux_pipe_n.sv
// N-input selector feeding a 2-entry registered buffer. The selected word
// and its index travel together; an out-of-range index stores zero and
// raises a sticky error flag.
module mux_pipe_n
    import mux_pipe_n_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    localparam int ENT_W = WIDTH + SEL_W;

    fifo_state_e      fifo_state;
    logic             push;
    logic             pop;
    logic             sel_oob;
    logic [WIDTH-1:0] sel_word;
    logic [ENT_W-1:0] head_entry;
    logic             sel_err_q, sel_err_d;

    // Handshake: a transfer happens on any edge where valid and ready are both high.
    assign in_ready  = (fifo_state != FIFO_FULL) && !flush && !rst;
    assign out_valid = (fifo_state != FIFO_EMPTY) && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // An index with no matching input falls through to the all-zero default.
    always_comb begin
        sel_word = '0;
        sel_oob  = (32'(sel) >= NUM_IN);
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(sel) == k) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        sel_err_d = sel_err_q | (push & sel_oob);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    mux_pipe_fifo2 #(
        .DW(ENT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .push_data({sel, sel_word}),
        .pop      (pop),
        .head_data(head_entry),
        .state    (fifo_state)
    );

    assign out_data = head_entry[WIDTH-1:0];
    assign out_sel  = head_entry[ENT_W-1:WIDTH];
    assign sel_err  = sel_err_q;

endmodule
